// File: rtl/servo_frame_sched.sv
// Four-channel RC servo frame scheduler with per-frame slew limiting.
// Ports: clk, rst (sync, active-high), en, cmd_valid/cmd_ready/cmd_ch/cmd_pw,
//        servo_out[3:0], frame_tick, busy[3:0].
module servo_frame_sched #(
    parameter int FRAME  = 1000000,
    parameter int PW_MIN = 50000,
    parameter int PW_MAX = 100000,
    parameter int PW_CTR = 75000,
    parameter int SLEW   = 1389
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_ch,
    input  logic [16:0] cmd_pw,
    output logic [3:0]  servo_out,
    output logic        frame_tick,
    output logic [3:0]  busy
);

    localparam int CW = $clog2(FRAME);

    localparam logic [CW-1:0] CNT_PRE  = CW'(FRAME - 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME - 1);

    localparam logic [16:0] W_MIN  = 17'(PW_MIN);
    localparam logic [16:0] W_MAX  = 17'(PW_MAX);
    localparam logic [16:0] W_CTR  = 17'(PW_CTR);
    localparam logic [16:0] W_SLEW = 17'(SLEW);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        UPDATE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nx;
    logic [16:0]     tgt [4];
    logic [16:0]     cur [4];

    function automatic logic [16:0] clamp_pw(input logic [16:0] p);
        logic [16:0] r;
        r = p;
        if (p < W_MIN) r = W_MIN;
        if (p > W_MAX) r = W_MAX;
        return r;
    endfunction

    // Move c toward t by at most W_SLEW. The difference is taken in the
    // direction that cannot underflow, and c+W_SLEW only happens when it
    // stays below t, so nothing ever wraps.
    function automatic logic [16:0] slew_step(
        input logic [16:0] c,
        input logic [16:0] t
    );
        logic [16:0] d;
        logic [16:0] r;
        if (t >= c) begin
            d = t - c;
            r = (d <= W_SLEW) ? t : c + W_SLEW;
        end else begin
            d = c - t;
            r = (d <= W_SLEW) ? t : c - W_SLEW;
        end
        return r;
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next-state logic: RUN covers cnt 0..FRAME-2, UPDATE is cnt FRAME-1,
    // so a frame is always exactly FRAME cycles and en only matters at
    // the frame boundary.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                cnt_nx = '0;
                if (en) state_nx = RUN;
            end
            RUN: begin
                if (cnt == CNT_PRE) begin
                    state_nx = UPDATE;
                    cnt_nx   = CNT_LAST;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            UPDATE: begin
                cnt_nx   = '0;
                state_nx = en ? RUN : IDLE;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Outputs are forced low while rst is high so the reset cycle itself
    // shows a quiet block, including mid-pulse.
    always_comb begin
        servo_out  = '0;
        frame_tick = 1'b0;
        cmd_ready  = 1'b0;
        busy       = '0;
        if (!rst) begin
            cmd_ready  = (state != UPDATE);
            frame_tick = (state == UPDATE);
            for (int i = 0; i < 4; i++) begin
                busy[i] = (cur[i] != tgt[i]);
                if (state == RUN)
                    servo_out[i] = (32'(cnt) < 32'(cur[i]));
            end
        end
    end

    // Width registers: targets take accepted commands, current widths
    // only move on the edge that leaves UPDATE.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                tgt[i] <= W_CTR;
                cur[i] <= W_CTR;
            end
        end else begin
            if (cmd_valid && cmd_ready)
                tgt[cmd_ch] <= clamp_pw(cmd_pw);
            if (state == UPDATE) begin
                for (int i = 0; i < 4; i++)
                    cur[i] <= slew_step(cur[i], tgt[i]);
            end
        end
    end

endmodule

// File: tb/tb_servo_frame_sched.sv
// Self-checking bench for servo_frame_sched (FRAME=1000, widths 50/75/100).
// Table vectors, hand sequences and random stimulus against a frame model.
module tb_servo_frame_sched;

    localparam int FRAME  = 1000;
    localparam int PW_MIN = 50;
    localparam int PW_MAX = 100;
    localparam int PW_CTR = 75;
    localparam int SLEW   = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_ch = 2'd0;
    logic [16:0] cmd_pw = 17'd0;
    logic        cmd_ready;
    logic [3:0]  servo_out;
    logic        frame_tick;
    logic [3:0]  busy;

    always #5 clk = ~clk;

    servo_frame_sched #(
        .FRAME(FRAME), .PW_MIN(PW_MIN), .PW_MAX(PW_MAX),
        .PW_CTR(PW_CTR), .SLEW(SLEW)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ch(cmd_ch), .cmd_pw(cmd_pw),
        .servo_out(servo_out), .frame_tick(frame_tick), .busy(busy)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int n_msg  = 0;
    bit chk_on = 1'b0;

    // Reference model: position within the frame (-1 when idle) and
    // integer widths, updated by the frame rules.
    int m_pos = -1;
    int m_tgt [4] = '{PW_CTR, PW_CTR, PW_CTR, PW_CTR};
    int m_cur [4] = '{PW_CTR, PW_CTR, PW_CTR, PW_CTR};

    function automatic int clampf(input int p);
        if (p < PW_MIN) return PW_MIN;
        if (p > PW_MAX) return PW_MAX;
        return p;
    endfunction

    function automatic int slewf(input int c, input int t);
        int d;
        d = t - c;
        if (d > SLEW) return c + SLEW;
        if (d < -SLEW) return c - SLEW;
        return t;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_pos <= -1;
            for (int i = 0; i < 4; i++) begin
                m_tgt[i] <= PW_CTR;
                m_cur[i] <= PW_CTR;
            end
        end else begin
            if (cmd_valid && m_pos != FRAME - 1)
                m_tgt[cmd_ch] <= clampf(int'(cmd_pw));
            if (m_pos == -1) begin
                m_pos <= en ? 0 : -1;
            end else if (m_pos == FRAME - 1) begin
                for (int i = 0; i < 4; i++)
                    m_cur[i] <= slewf(m_cur[i], m_tgt[i]);
                m_pos <= en ? 0 : -1;
            end else begin
                m_pos <= m_pos + 1;
            end
        end
    end

    // {servo_out, frame_tick, busy, cmd_ready}
    function automatic logic [9:0] model_out();
        logic [3:0] s;
        logic [3:0] b;
        logic       t;
        logic       r;
        s = '0; b = '0; t = 1'b0; r = 1'b0;
        if (!rst) begin
            r = (m_pos != FRAME - 1);
            t = (m_pos == FRAME - 1);
            for (int i = 0; i < 4; i++) begin
                b[i] = (m_cur[i] != m_tgt[i]);
                s[i] = (m_pos >= 0) && (m_pos < FRAME - 1)
                       && (m_pos < m_cur[i]);
            end
        end
        return {s, t, b, r};
    endfunction

    logic [3:0] s_servo;
    logic       s_tick;

    task automatic cmp(input string name, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t",
                     name, got, exp, $time);
        end
    endtask

    // One clock: compare against the model at the falling edge, then
    // return 1 time unit after the rising edge for the next input change.
    task automatic step();
        logic [9:0] e;
        logic [9:0] g;
        @(negedge clk);
        if (chk_on) begin
            e = model_out();
            g = {servo_out, frame_tick, busy, cmd_ready};
            n_chk++;
            if (g !== e) begin
                n_fail++;
                if (n_msg < 20)
                    $display("FAIL model_cycle: got %b, expected %b at %0t",
                             g, e, $time);
                n_msg++;
            end
        end
        s_servo = servo_out;
        s_tick  = frame_tick;
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic wait_tick();
        int k;
        k = 0;
        s_tick = 1'b0;
        while (!s_tick && k < 3 * FRAME) begin
            step();
            k++;
        end
        if (!s_tick) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_tick: got no frame_tick, expected one within %0d cycles",
                     3 * FRAME);
        end
    endtask

    int mw [4];
    int m_ticks;
    bit m_last;

    // Count high cycles per line over one frame window.
    task automatic measure();
        for (int i = 0; i < 4; i++) mw[i] = 0;
        m_ticks = 0;
        for (int c = 0; c < FRAME; c++) begin
            step();
            for (int i = 0; i < 4; i++)
                if (s_servo[i]) mw[i]++;
            if (s_tick) m_ticks++;
        end
        m_last = s_tick;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en = 1'b0;
        cmd_valid = 1'b0;
        steps(2);
        rst = 1'b0;
    endtask

    typedef struct {
        int ch;
        int pw;
        int e0;
        int e1;
        int e2;
        int e3;
    } vec_t;

    vec_t vt [7];

    initial begin
        int ew [4];
        int hi;

        vt[0] = '{1, 100,    85, 95, 100, 100};
        vt[1] = '{2, 20,     65, 55, 50,  50};
        vt[2] = '{3, 500,    85, 95, 100, 100};
        vt[3] = '{0, 80,     80, 80, 80,  80};
        vt[4] = '{0, 0,      65, 55, 50,  50};
        vt[5] = '{2, 131071, 85, 95, 100, 100};
        vt[6] = '{1, 74,     74, 74, 74,  74};

        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_on = 1'b1;

        // Reset state while rst is held
        cmp("rst_ready", int'(cmd_ready), 0);
        cmp("rst_busy", int'(busy), 0);
        cmp("rst_servo", int'(servo_out), 0);

        // Table: command in IDLE, then five frames of widths
        foreach (vt[v]) begin
            do_reset();
            en = 1'b1;
            cmd_valid = 1'b1;
            cmd_ch = 2'(vt[v].ch);
            cmd_pw = 17'(vt[v].pw);
            step();
            cmd_valid = 1'b0;
            for (int f = 0; f < 5; f++) begin
                measure();
                ew[0] = PW_CTR; ew[1] = PW_CTR;
                ew[2] = PW_CTR; ew[3] = PW_CTR;
                case (f)
                    1: ew[vt[v].ch] = vt[v].e0;
                    2: ew[vt[v].ch] = vt[v].e1;
                    3: ew[vt[v].ch] = vt[v].e2;
                    4: ew[vt[v].ch] = vt[v].e3;
                    default: ;
                endcase
                for (int i = 0; i < 4; i++)
                    cmp($sformatf("vec%0d_f%0d_w%0d", v, f, i), mw[i], ew[i]);
                cmp($sformatf("vec%0d_f%0d_ticks", v, f), m_ticks, 1);
                cmp($sformatf("vec%0d_f%0d_ticklast", v, f), int'(m_last), 1);
            end
            cmp($sformatf("vec%0d_busy_end", v), int'(busy), 0);
        end

        // Command held across UPDATE; last accepted wins on ch0
        do_reset();
        en = 1'b1;
        step();
        steps(FRAME - 1);
        cmd_valid = 1'b1;
        cmd_ch = 2'd0;
        cmd_pw = 17'd60;
        #1;
        cmp("upd_tick", int'(frame_tick), 1);
        cmp("upd_ready", int'(cmd_ready), 0);
        step();
        cmp("post_upd_ready", int'(cmd_ready), 1);
        cmp("post_upd_busy0", int'(busy[0]), 0);
        step();
        cmp("accept60_busy0", int'(busy[0]), 1);
        cmd_pw = 17'd90;
        step();
        cmd_valid = 1'b0;
        wait_tick();
        measure();
        cmp("b2b_f1_w0", mw[0], 85);
        measure();
        cmp("b2b_f2_w0", mw[0], 90);
        cmp("b2b_busy", int'(busy), 0);

        // en dropped mid-frame: frame completes, then IDLE
        wait_tick();
        steps(300);
        en = 1'b0;
        steps(FRAME - 301);
        cmp("endrop_tick", int'(frame_tick), 1);
        step();
        cmp("idle_servo", int'(servo_out), 0);
        cmp("idle_tick", int'(frame_tick), 0);
        cmp("idle_ready", int'(cmd_ready), 1);
        hi = 0;
        for (int k = 0; k < 50; k++) begin
            step();
            if (s_servo != 4'd0 || s_tick) hi++;
        end
        cmp("idle_quiet", hi, 0);

        // rst mid-frame and mid-slew
        cmd_valid = 1'b1;
        cmd_ch = 2'd2;
        cmd_pw = 17'd100;
        en = 1'b1;
        step();
        cmd_valid = 1'b0;
        wait_tick();
        steps(40);
        cmp("pre_rst_servo2", int'(servo_out[2]), 1);
        cmp("pre_rst_busy2", int'(busy[2]), 1);
        rst = 1'b1;
        #1;
        cmp("rst_mid_servo", int'(servo_out), 0);
        cmp("rst_mid_busy", int'(busy), 0);
        cmp("rst_mid_ready", int'(cmd_ready), 0);
        step();
        rst = 1'b0;
        cmp("after_rst_servo", int'(servo_out), 0);
        cmp("after_rst_busy", int'(busy), 0);
        step();
        measure();
        for (int i = 0; i < 4; i++)
            cmp($sformatf("after_rst_w%0d", i), mw[i], PW_CTR);

        // Random traffic against the model
        do_reset();
        en = 1'b1;
        for (int c = 0; c < 15000; c++) begin
            cmd_valid = ($urandom_range(0, 29) == 0);
            cmd_ch = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0)
                cmd_pw = 17'($urandom);
            else
                cmd_pw = 17'($urandom_range(30, 120));
            if ($urandom_range(0, 1999) == 0) en = ~en;
            rst = ($urandom_range(0, 4999) == 0);
            step();
        end
        rst = 1'b0;
        cmd_valid = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/servo_frame_sched.md
SERVO_FRAME_SCHED -- requirements
Module: servo_frame_sched

Interface
REQ-001 The block SHALL have parameter FRAME, default 1000000, meaning servo frame length in clk cycles (20 ms at 50 MHz).
REQ-002 The block SHALL have parameter PW_MIN, default 50000, meaning minimum pulse width in cycles.
REQ-003 The block SHALL have parameter PW_MAX, default 100000, meaning maximum pulse width in cycles; PW_MAX < FRAME-1 is required.
REQ-004 The block SHALL have parameter PW_CTR, default 75000, meaning center/reset pulse width in cycles.
REQ-005 The block SHALL have parameter SLEW, default 1389, meaning maximum pulse-width change per frame, nonzero.
REQ-006 The block SHALL have port clk, input, 1 bit, meaning the single system clock.
REQ-007 The block SHALL have port rst, input, 1 bit, meaning synchronous active-high reset.
REQ-008 The block SHALL have port en, input, 1 bit, meaning run request for frame generation.
REQ-009 The block SHALL have port cmd_valid, input, 1 bit, meaning command present.
REQ-010 The block SHALL have port cmd_ready, output, 1 bit, meaning command can be accepted this cycle.
REQ-011 The block SHALL have port cmd_ch, input, 2 bits, meaning target channel 0-3.
REQ-012 The block SHALL have port cmd_pw, input, 17 bits, meaning requested pulse width in cycles.
REQ-013 The block SHALL have port servo_out, output, 4 bits, meaning one servo pulse line per channel.
REQ-014 The block SHALL have port frame_tick, output, 1 bit, meaning one-cycle strobe marking the frame update cycle.
REQ-015 The block SHALL have port busy, output, 4 bits, meaning that channel's current width differs from its target.

Function
REQ-016 The block SHALL implement states IDLE, RUN and UPDATE with one shared frame counter cnt (0..FRAME-1) and per-channel registers tgt[i] and cur[i].
REQ-017 IDLE: cnt held at 0 and servo_out=0; when en=1, the next state SHALL be RUN with cnt=0.
REQ-018 RUN: cnt SHALL increment each cycle; at cnt==FRAME-2 the next state SHALL be UPDATE with cnt=FRAME-1.
REQ-019 UPDATE SHALL last exactly one cycle with frame_tick=1; the next state SHALL be RUN with cnt=0 if en=1, else IDLE; frame period is therefore exactly FRAME cycles and en deassertion SHALL never truncate a frame.
REQ-020 In RUN, servo_out[i] SHALL be 1 iff cnt < cur[i]; servo_out SHALL be 0 in IDLE and UPDATE.
REQ-021 cmd_ready SHALL be 1 in IDLE and RUN and 0 in UPDATE and during reset.
REQ-022 On cmd_valid&&cmd_ready, tgt[cmd_ch] SHALL take cmd_pw clamped to [PW_MIN,PW_MAX] on the next edge; commands arriving back-to-back to the same channel SHALL follow last-accepted-wins.
REQ-023 cur[i] SHALL change only on the edge leaving UPDATE: if |tgt[i]-cur[i]| <= SLEW then cur[i]=tgt[i], else cur[i] moves toward tgt[i] by exactly SLEW; width arithmetic SHALL be unsigned 17-bit without wrap.
REQ-024 Commands accepted in IDLE SHALL update tgt only; cur SHALL take effect via UPDATE after RUN resumes.
REQ-025 busy[i] SHALL be combinational (cur[i] != tgt[i]).

Reset
REQ-026 When rst=1 at a clock edge, the block SHALL enter IDLE, set cnt=0, tgt[i]=cur[i]=PW_CTR, and hold servo_out=0, frame_tick=0, busy=0 and cmd_ready=0 for that cycle.
REQ-027 A rst asserted mid-frame or mid-slew SHALL take effect on that edge with no partial pulse completed.

Verification
(Bench parameters: FRAME=1000, PW_MIN=50, PW_MAX=100, PW_CTR=75, SLEW=10.)
REQ-028 Reset, then en=1 -> each servo_out line high for 75 cycles per 1000-cycle frame, and frame_tick pulses every 1000 cycles at cnt=999.
REQ-029 Command ch1 pw=100 -> ch1 widths 85, 95, 100, 100 in successive frames, with busy[1] clearing after the third update.
REQ-030 Command ch2 pw=20, then ch3 pw=500 -> tgt clamped to 50 and 100 respectively.
REQ-031 cmd_valid held across the UPDATE cycle -> cmd_ready=0 there, and the command is accepted on the following cycle; two commands to ch0 (60, then 90) -> ch0 slews toward 90.
REQ-032 en dropped at cnt=300 -> frame completes to cnt=999, then IDLE with outputs 0; rst asserted at cnt=40 of a frame -> all outputs 0 on the next edge and all widths return to 75.
